bcd_to_bin_seq: RTL

- Sequential packed-BCD to binary decoder, the inverse of the binary-to-BCD stage at the calculator ALU output.
- Takes NDIG BCD digits from the keypad/entry path, accumulates one digit per clock (acc = acc*10 + digit, most significant digit first), and presents an unsigned binary operand to the ALU.
- Uses a valid/ready handshake on both input and output, and flags non-BCD nibbles.

---
 rtl/bcd_to_bin_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary decoder.
// The block accepts one operand of NDIG BCD digits and folds in one digit per
// clock, most significant digit first (acc = acc*10 + digit). It then presents
// the unsigned binary result, or 0 with out_err set if any nibble was above 9.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. A producer holds valid and its data until that edge. Ready never
// depends combinationally on valid. Here in_ready is high only in IDLE and
// out_valid is high only in HOLD, so at most one operand is in flight.
module bcd_to_bin_seq #(
    parameter int NDIG = 4,
    parameter int BW   = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] in_bcd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BW-1:0]     out_bin,
    output logic              out_err,
    output logic [1:0]        dbg_state
);

    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [4*NDIG-1:0]   sreg;
    logic [BW-1:0]       acc;
    logic [CW-1:0]       cnt;
    logic                err;

    logic                accept;
    logic                last_digit;
    logic [3:0]          digit;
    logic [BW-1:0]       acc_nxt;
    logic                err_nxt;

    // The FSM state is exported so that checkers can observe it directly.
    assign dbg_state = state;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs, decoded from the current state.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        last_digit = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (cnt == '0) begin
                    last_digit = 1'b1;
                    state_nxt  = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // One accumulation step: acc*10 + d, done as shift-and-add in BW bits.
    // Illegal digits may wrap the sum; that is harmless because the result
    // is forced to 0 whenever the error flag is set.
    always_comb begin
        digit   = sreg[4*NDIG-1 -: 4];
        acc_nxt = (acc << 3) + (acc << 1) + {{(BW-4){1'b0}}, digit};
        err_nxt = err | (digit > 4'd9);
    end

    // Datapath: capture on accept, fold one digit per CONV cycle, and latch
    // the result on the last digit so it stays stable through HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            acc     <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            out_bin <= '0;
            out_err <= 1'b0;
        end else if (accept) begin
            sreg <= in_bcd;
            acc  <= '0;
            cnt  <= CNT_LAST;
            err  <= 1'b0;
        end else if (state == CONV) begin
            sreg <= sreg << 4;
            acc  <= acc_nxt;
            err  <= err_nxt;
            if (last_digit) begin
                out_bin <= err_nxt ? '0 : acc_nxt;
                out_err <= err_nxt;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule
